mdu_iter: RTL and testbench
===========================

# mdu_iter

Multi-cycle multiply/divide unit for the execute stage, replacing the single-cycle combinational multiply/divide path. It supports signed and unsigned variants, a parametrised data width and a valid/ready handshake on both sides. It also supports a pipeline flush, so the execute stage can stall on long operations and cancel them on exceptions or branch redirects.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; even, ≥ 8
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  cancel any in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU; 7 reserved
- oprand1  in  DATA_WIDTH  multiplicand / dividend
- oprand2  in  DATA_WIDTH  multiplier / divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  result, stable while out_valid && !out_ready

## Operation
- FSM states: IDLE, CALC, DONE.
- Reset state is IDLE.
  - Reset values: in_ready=1, out_valid=0, result=0, counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch operands, op and signs; take absolute values for signed ops (MUL, MULH, DIV, MOD).
  - Special cases go directly to DONE:
    - DIV/DIVU with oprand2==0: result = all ones.
    - MOD/MODU with oprand2==0: result = oprand1.
    - DIV with oprand1==MIN_INT and oprand2==-1: result = MIN_INT.
    - MOD with the same operands: result = 0.
    - op==7: result = 0.
  - Every other op goes to CALC with counter=DATA_WIDTH.
- CALC:
  - Multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2*DATA_WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each cycle. When the counter reaches 1, the final iteration is performed and the state goes to DONE.
  - The result register is loaded on entry to DONE, after sign correction:
    - Product is negated if signs differ.
    - Quotient is negated if signs differ.
    - Remainder takes the sign of the dividend.
- DONE:
  - out_valid=1.
  - On out_ready: go to IDLE. No new request is accepted in that same cycle; in_ready is high only in IDLE.
- Result selection:
  - MUL: low half of the product.
  - MULH/MULHU: high half of the product.
  - DIV/DIVU: quotient.
  - MOD/MODU: remainder.
- flush:
  - Next state is IDLE, out_valid drops and the in-flight result is discarded.
  - A request presented with in_valid in the same cycle as flush is not accepted.
  - rst has priority over flush; flush has priority over every other transition.
- Unused upper op encodings never hang the unit.

## Timing
- Normal op accepted at edge N:
  - CALC for cycles N+1 … N+DATA_WIDTH.
  - out_valid is high from cycle N+DATA_WIDTH+1.
  - Latency is DATA_WIDTH+1 cycles: 33 for DATA_WIDTH=32.
- Special-case op: out_valid is high at cycle N+1.
- Back-to-back throughput: one op per latency+1 cycles, because of the idle bubble after out_ready.
- in_ready, out_valid and result are all registered outputs, with no combinational path from inputs.
- Backpressure: out_valid and result hold indefinitely while out_ready=0.

## Configuration
- MDU_FAST_MUL_EN:
  - Defined: MUL/MULH/MULHU use a single-cycle DATA_WIDTH×DATA_WIDTH multiplier and go IDLE→DONE, with out_valid at N+1. Divide is unchanged.
  - Undefined: all multiplies take the iterative CALC path with DATA_WIDTH+1 latency.
  - Result values are identical in both builds.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), out_ready=1:
  - Required: result 0xFFFFFFEB.
  - out_valid at cycle 33, or at cycle 1 with MDU_FAST_MUL_EN.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV -7 / 2 → 0xFFFFFFFD (-3); MOD -7 % 2 → 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
  - Each takes 33 cycles.
- Special cases, each with out_valid at cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - MODU 5%0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - MOD with the same operands → 0.
- Flush during CALC at cycle 10:
  - Required: in_ready=1 at cycle 11, and out_valid never rises for the cancelled op.
  - A following DIV 100/7 returns 14.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: result stable and in_ready=0 throughout.
  - After out_ready pulses, in_ready=1 the next cycle.
  - Reset mid-CALC gives out_valid=0 and result=0 the next cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide, valid/ready + flush.
// Optional MDU_FAST_MUL_EN: multiplies complete in one cycle through a full-width multiplier.
module mdu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] oprand1,
    input  logic [DATA_WIDTH-1:0] oprand2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_MOD,
        OP_MODU,
        OP_RSVD
    } op_t;

    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    op_t              op_in;
    logic             in_signed, s1, s2;
    logic [W-1:0]     abs1, abs2;
    logic             in_is_mul, in_is_div, in_is_mod;

    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_next;
    logic [W:0]       div_trial;
    logic [2*W-1:0]   div_next;
    logic [2*W-1:0]   step;
    logic [2*W-1:0]   prod_s;
    logic [W-1:0]     quo_s, rem_s;
    logic [W-1:0]     final_res;
`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0]   fast_prod;
    logic [2*W-1:0]   fast_prod_s;
`endif

    always_comb begin
        op_in     = op_t'(op);
        in_signed = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                    (op_in == OP_DIV) || (op_in == OP_MOD);
        s1        = in_signed & oprand1[W-1];
        s2        = in_signed & oprand2[W-1];
        abs1      = s1 ? -oprand1 : oprand1;
        abs2      = s2 ? -oprand2 : oprand2;
        in_is_mul = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHU);
        in_is_div = (op_in == OP_DIV) || (op_in == OP_DIVU);
        in_is_mod = (op_in == OP_MOD) || (op_in == OP_MODU);
`ifdef MDU_FAST_MUL_EN
        fast_prod   = {{W{1'b0}}, abs1} * {{W{1'b0}}, abs2};
        fast_prod_s = (s1 ^ s2) ? -fast_prod : fast_prod;
`endif
    end

    // One iteration of each algorithm; acc_q holds {partial, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + ({1'b0, b_q} & {(W+1){acc_q[0]}});
        mul_next  = {mul_sum, acc_q[W-1:1]};
        div_trial = acc_q[2*W-1:W-1] - {1'b0, b_q};
        div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        step      = (op_q == OP_MUL || op_q == OP_MULH || op_q == OP_MULHU) ? mul_next : div_next;
        prod_s    = neg_q ? -step : step;
        quo_s     = neg_q ? -step[W-1:0] : step[W-1:0];
        rem_s     = rem_neg_q ? -step[2*W-1:W] : step[2*W-1:W];
        case (op_q)
            OP_MUL:            final_res = prod_s[W-1:0];
            OP_MULH, OP_MULHU: final_res = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:   final_res = quo_s;
            OP_MOD, OP_MODU:   final_res = rem_s;
            default:           final_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d      = op_in;
                    neg_d     = s1 ^ s2;
                    rem_neg_d = s1;
                    b_d       = abs2;
                    acc_d     = {{W{1'b0}}, abs1};
                    if (in_is_mul) begin
`ifdef MDU_FAST_MUL_EN
                        result_d = (op_in == OP_MUL) ? fast_prod_s[W-1:0] : fast_prod_s[2*W-1:W];
                        state_d  = DONE;
`else
                        cnt_d   = CNT_WIDTH'(DATA_WIDTH);
                        state_d = CALC;
`endif
                    end else if (in_is_div || in_is_mod) begin
                        if (oprand2 == '0) begin
                            result_d = in_is_div ? '1 : oprand1;
                            state_d  = DONE;
                        end else if ((op_in == OP_DIV || op_in == OP_MOD) &&
                                     oprand1 == MIN_INT && oprand2 == '1) begin
                            result_d = (op_in == OP_DIV) ? MIN_INT : '0;
                            state_d  = DONE;
                        end else begin
                            cnt_d   = CNT_WIDTH'(DATA_WIDTH);
                            state_d = CALC;
                        end
                    end else begin
                        result_d = '0;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized bench for mdu_iter against an arithmetic reference model (DATA_WIDTH=32).
module tb_mdu_iter;

    localparam int W = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  oprand1;
    logic [W-1:0]  oprand2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    mdu_iter #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .oprand1   (oprand1),
        .oprand2   (oprand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        int ia, ib, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = ua * ub; return p[63:32]; end
            3'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                q = ia / ib;
                return q;
            end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd5: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
                q = ia % ib;
                return q;
            end
            3'd6: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (o == 3'd7) return 1;
        if (o <= 3'd2) begin
`ifdef MDU_FAST_MUL_EN
            return 1;
`else
            return W + 1;
`endif
        end
        if (b == 0) return 1;
        if ((o == 3'd3 || o == 3'd5) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_INT;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready"}, in_ready, 1);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int lat;
        wait_ready(tag);
        in_valid = 1'b1;
        op       = o;
        oprand1  = a;
        oprand2  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " lat"}, lat, ref_latency(o, a, b));
        check({tag, " res"}, result, ref_result(o, a, b));
        check({tag, " busy"}, in_ready, 0);
        @(posedge clk); #1;
        check({tag, " ret"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int n;
        logic seen;
        logic [31:0] exp;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0;
        oprand1 = '0; oprand2 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "mul 7*-3");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh min*min");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu max*max");
        do_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, "div -7/2");
        do_op(3'd5, 32'hFFFF_FFF9, 32'h0000_0002, "mod -7%2");
        do_op(3'd4, 32'hFFFF_FFFF, 32'h0000_0002, "divu max/2");
        do_op(3'd4, 32'd5, 32'd0, "divu 5/0");
        do_op(3'd6, 32'd5, 32'd0, "modu 5%0");
        do_op(3'd3, MIN_INT, 32'hFFFF_FFFF, "div ovf");
        do_op(3'd5, MIN_INT, 32'hFFFF_FFFF, "mod ovf");
        do_op(3'd7, 32'd9, 32'd3, "op7");

        // Flush mid-CALC with a competing request that must be ignored.
        wait_ready("flush");
        in_valid = 1'b1; op = 3'd3; oprand1 = 32'd123; oprand2 = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        flush = 1'b1; in_valid = 1'b1; op = 3'd4; oprand2 = 32'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush in_ready", in_ready, 1);
        check("flush out_valid", out_valid, 0);
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush no valid", seen, 0);
        do_op(3'd3, 32'd100, 32'd7, "div 100/7");

        // Backpressure in DONE.
        out_ready = 1'b0;
        exp = ref_result(3'd2, 32'hFFFF_FFFF, 32'h1234_5678);
        wait_ready("bp");
        in_valid = 1'b1; op = 3'd2; oprand1 = 32'hFFFF_FFFF; oprand2 = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold res", result, exp);
            check("bp hold flags", {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", {out_valid, in_ready}, 2'b01);

        // Flush while holding a result in DONE.
        out_ready = 1'b0;
        wait_ready("flush done");
        in_valid = 1'b1; op = 3'd4; oprand1 = 32'd9; oprand2 = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush done valid", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush done drop", {out_valid, in_ready}, 2'b01);
        out_ready = 1'b1;

        // Reset mid-CALC.
        wait_ready("rst calc");
        in_valid = 1'b1; op = 3'd4; oprand1 = 32'd1000; oprand2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst calc valid", out_valid, 0);
        check("rst calc result", result, 0);
        check("rst calc ready", in_ready, 1);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            do_op(ro, ra, rb, $sformatf("rand%0d op%0d %h %h", i, ro, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
